// File: rtl/onehot_shift_sequencer.sv
// Rotating one-hot word source for the 4-to-2 encoder, with a valid/ready handshake,
// direction control, checked seed load, wrap pulse and a modulo transfer counter.
module onehot_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             wrap,
  output logic             load_err,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer, stalled, accept;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v, input logic right);
    return right ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // The set bit leaves the word at the end it is moving towards.
  function automatic logic wraps(input logic [WIDTH-1:0] v, input logic right);
    return right ? v[0] : v[WIDTH-1];
  endfunction

  assign xfer    = (state_q == ACTIVE) && d_ready;
  assign stalled = (state_q == ACTIVE) && !d_ready;
  assign accept  = load && !stalled;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (xfer) begin
      cnt_d  = cnt_q + CNT_W'(1);
      word_d = rotate(word_q, dir);
      wrap_d = wraps(word_q, dir);
    end

    // A legal seed overrides the rotation but the transfer still counts.
    if (accept) begin
      if (is_onehot(load_val)) begin
        word_d = load_val;
        wrap_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (en) state_d = ACTIVE;
      ACTIVE:  if (!en && xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= WIDTH'(1);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_out    = word_q;
  assign d_valid  = (state_q == ACTIVE);
  assign wrap     = wrap_q;
  assign load_err = err_q;
  assign step_cnt = cnt_q;

endmodule
